// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// PC step and redirect alignment mask.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned ALIGN_MASK = 3;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised show-ahead FIFO with synchronous clear; used both as the
// prefetch buffer and as the in-flight request tag queue.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read once
  // count says it holds data, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// Pipelined instruction fetch: PC, credit-limited imem issue, prefetch FIFO,
// redirect flush. Optional perf counters under `FETCH_PERF_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter int                MAX_OUT    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int OUT_W   = $clog2(MAX_OUT + 1);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + DATA_W;

  fetch_state_e      state, next_state;
  logic [ADDR_W-1:0] pc;
  logic [OUT_W-1:0]  outstanding, outstanding_next;
  logic [OUT_W-1:0]  discard, discard_next;
  logic [OUT_W-1:0]  remaining;
  logic              accept_rsp;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0] fifo_rdata;

  logic [ADDR_W-1:0] tag_pc;
  logic [OUT_W-1:0]  tag_count;
  logic              tag_full, tag_empty;

  // Only responses in RUN outside a redirect cycle are right-path words.
  assign accept_rsp = imem_rvalid & (state == ST_RUN) & ~redirect_valid;
  assign remaining  = outstanding - OUT_W'(imem_rvalid);

  assign imem_req = (state == ST_RUN) & ~redirect_valid
                  & (outstanding < OUT_W'(MAX_OUT))
                  & ((int'(fifo_count) + int'(outstanding)) < FIFO_DEPTH);
  assign imem_addr        = pc;
  assign outstanding_next = remaining + OUT_W'(imem_req);

  assign if_valid = ~fifo_empty & ~redirect_valid;
  assign fifo_pop = if_valid & if_ready;
  assign if_pc    = fifo_rdata[DATA_W +: ADDR_W];
  assign if_instr = fifo_rdata[DATA_W-1:0];

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state   = state;
    discard_next = discard;
    if (redirect_valid) begin
      discard_next = remaining;
    end else if (state == ST_DRAIN && imem_rvalid) begin
      discard_next = discard - 1'b1;
    end
    unique case (state)
      ST_IDLE:  next_state = ST_RUN;
      ST_RUN:   if (redirect_valid && remaining != '0) next_state = ST_DRAIN;
      ST_DRAIN: if (discard_next == '0) next_state = ST_RUN;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= next_state;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (redirect_valid) begin
        pc <= redirect_pc & ~ADDR_W'(ALIGN_MASK);
      end else if (imem_req) begin
        pc <= pc + ADDR_W'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_prefetch (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept_rsp),
    .pop   (fifo_pop),
    .clear (redirect_valid),
    .wdata ({tag_pc, imem_rdata}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Tags of dropped responses are discarded wholesale by the redirect clear.
  fetch_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (ADDR_W)
  ) u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (imem_req),
    .pop   (accept_rsp),
    .clear (redirect_valid),
    .wdata (pc),
    .rdata (tag_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  logic unused_status;
  assign unused_status = &{1'b0, fifo_full, tag_count, tag_full, tag_empty};

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(fifo_pop);
      perf_stall   <= perf_stall + 32'(if_valid & ~if_ready);
      perf_flushed <= perf_flushed + 32'(imem_rvalid & ~accept_rsp);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: transaction-level memory and decode
// scoreboard, randomized ready/redirect traffic, plus a RESET_PC=F8 instance.
module tb_fetch_stage;

  localparam int FIFO_DEPTH = 4;
  localparam int MAX_OUT    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_rvalid, if_valid, if_ready, redirect_valid;
  logic [7:0]  imem_addr, if_pc, redirect_pc;
  logic [31:0] imem_rdata, if_instr;

  logic        w_req, w_rvalid, w_valid;
  logic        w_ready = 1'b1;
  logic        w_redir = 1'b0;
  logic [7:0]  w_addr, w_pc;
  logic [7:0]  w_target = 8'h00;
  logic [31:0] w_rdata, w_instr;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_flushed;
  logic [31:0] w_pf, w_ps, w_pfl;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flushed(perf_flushed)
`endif
  );

  fetch_stage #(.RESET_PC(8'hF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .if_valid(w_valid), .if_ready(w_ready), .if_pc(w_pc), .if_instr(w_instr),
    .redirect_valid(w_redir), .redirect_pc(w_target)
`ifdef FETCH_PERF_EN
    , .perf_fetched(w_pf), .perf_stall(w_ps), .perf_flushed(w_pfl)
`endif
  );

  typedef struct {
    logic [7:0] addr;
    int         due;
    logic       stale;
  } req_t;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } word_t;

  req_t        inflight[$];
  word_t       buffered[$];
  word_t       w_seen[$];
  logic [7:0]  next_req_pc;
  logic [31:0] salt;
  int          cyc, lat;
  int          vectors, miscompares;
  int          n_fetched, n_stall, n_flushed;
  logic        w_pend;
  logic [7:0]  w_pend_addr;
  logic        last_req, last_valid, last_xfer;
  logic [7:0]  last_addr, last_pc;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3} ^ salt;
  endfunction

  // One clock cycle: drive decode/execute/memory, score the DUT, advance the model.
  task automatic tick(input logic rdy, input logic redir, input logic [7:0] target);
    logic  exp_valid;
    req_t  r;
    if_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = target;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    if (inflight.size() > 0 && inflight[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(inflight[0].addr);
    end
    w_rvalid = w_pend;
    w_rdata  = mem_word(w_pend_addr);
    #1;
    exp_valid = (buffered.size() > 0) && !redir;
    vectors++;
    if (if_valid !== exp_valid) begin
      miscompares++;
      $display("FAIL if_valid cyc=%0d got=%0b exp=%0b", cyc, if_valid, exp_valid);
    end
    if (exp_valid) begin
      vectors++;
      if (if_pc !== buffered[0].pc || if_instr !== buffered[0].instr) begin
        miscompares++;
        $display("FAIL if_word cyc=%0d got=%h/%h exp=%h/%h", cyc, if_pc, if_instr,
                 buffered[0].pc, buffered[0].instr);
      end
    end
    vectors++;
    if (imem_addr !== next_req_pc) begin
      miscompares++;
      $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, next_req_pc);
    end
    if (imem_req === 1'b1) begin
      vectors++;
      if (redir || inflight.size() >= MAX_OUT
          || buffered.size() + inflight.size() >= FIFO_DEPTH
          || (inflight.size() > 0 && inflight[inflight.size()-1].stale)) begin
        miscompares++;
        $display("FAIL issue_rule cyc=%0d got req=1 exp req=0 (out=%0d buf=%0d redir=%0b)",
                 cyc, inflight.size(), buffered.size(), redir);
      end
    end
    last_req   = imem_req;
    last_addr  = imem_addr;
    last_valid = if_valid;
    last_pc    = if_pc;
    last_xfer  = exp_valid && rdy;
    if (exp_valid && !rdy) n_stall++;
    if (last_xfer) begin
      n_fetched++;
      void'(buffered.pop_front());
    end
    if (imem_rvalid) begin
      r = inflight.pop_front();
      if (r.stale || redir) n_flushed++;
      else buffered.push_back('{pc: r.addr, instr: mem_word(r.addr)});
    end
    if (redir) begin
      buffered.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      next_req_pc = target & 8'hFC;
    end else if (imem_req === 1'b1) begin
      inflight.push_back('{addr: imem_addr, due: cyc + lat, stale: 1'b0});
      next_req_pc = next_req_pc + 8'd4;
    end
    if (w_valid) w_seen.push_back('{pc: w_pc, instr: w_instr});
    w_pend      = w_req;
    w_pend_addr = w_addr;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    w_rvalid       = 1'b0;
    inflight.delete();
    buffered.delete();
    w_seen.delete();
    next_req_pc = 8'h00;
    w_pend      = 1'b0;
    w_pend_addr = 8'h00;
    n_fetched   = 0;
    n_stall     = 0;
    n_flushed   = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // After release: one IDLE cycle without a request, then a request at RESET_PC.
  task automatic check_start(input string tag);
    tick(1'b1, 1'b0, 8'h00);
    vectors++;
    if (last_req !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle_req got=%0b exp=0", tag, last_req);
    end
    tick(1'b1, 1'b0, 8'h00);
    vectors++;
    if (last_req !== 1'b1 || last_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL %s_first_req got=%0b@%h exp=1@00", tag, last_req, last_addr);
    end
  endtask

  task automatic wait_two_inflight(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (inflight.size() == 2 && !inflight[0].stale && !inflight[1].stale
          && inflight[0].due > cyc) begin
        ok = 1'b1;
        return;
      end
      tick(1'b1, 1'b0, 8'h00);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs got req=%b valid=%b addr=%h exp 0/0/00",
               imem_req, if_valid, imem_addr);
    end
    lat = 1;
    do_reset();
    check_start("reset");
  endtask

  task automatic test_stream();
    int got;
    do_reset();
    lat = 1;
    repeat (4) tick(1'b1, 1'b0, 8'h00);
    got = 0;
    repeat (16) begin
      tick(1'b1, 1'b0, 8'h00);
      if (last_xfer) got++;
    end
    vectors++;
    if (got != 16) begin
      miscompares++;
      $display("FAIL stream_throughput got=%0d exp=16 transfers", got);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] hold_pc;
    do_reset();
    lat = 1;
    repeat (6) tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    hold_pc = last_pc;
    repeat (9) begin
      tick(1'b0, 1'b0, 8'h00);
      vectors++;
      if (last_valid !== 1'b1 || last_pc !== hold_pc) begin
        miscompares++;
        $display("FAIL bp_hold got=%b/%h exp=1/%h", last_valid, last_pc, hold_pc);
      end
    end
    vectors++;
    if (last_req !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_issue_stop got req=%b exp=0", last_req);
    end
    repeat (8) begin
      tick(1'b1, 1'b0, 8'h00);
      vectors++;
      if (last_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_release_gap cyc=%0d got valid=%b exp=1", cyc, last_valid);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    logic ok;
    int   fl0;
    do_reset();
    lat = 3;
    wait_two_inflight(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL redir_setup got=timeout exp=2 outstanding");
    end
    fl0 = n_flushed;
    tick(1'b1, 1'b1, 8'h42);
    vectors++;
    if (last_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_mask got valid=%b exp=0", last_valid);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(1'b1, 1'b0, 8'h00);
      ok = last_req;
    end
    vectors++;
    if (!ok || last_addr !== 8'h40 || n_flushed - fl0 != 2) begin
      miscompares++;
      $display("FAIL redir_first_req got=%b@%h flushed=%0d exp=1@40 flushed=2",
               ok, last_addr, n_flushed - fl0);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(1'b1, 1'b0, 8'h00);
      ok = last_valid;
    end
    vectors++;
    if (!ok || last_pc !== 8'h40) begin
      miscompares++;
      $display("FAIL redir_first_pc got=%b/%h exp=1/40", ok, last_pc);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc = '{8'hF8, 8'hFC, 8'h00, 8'h04};
    do_reset();
    lat = 1;
    repeat (12) tick(1'b1, 1'b0, 8'h00);
    vectors++;
    if (w_seen.size() < 4) begin
      miscompares++;
      $display("FAIL wrap_count got=%0d exp>=4", w_seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (w_seen[i].pc !== exp_pc[i] || w_seen[i].instr !== mem_word(exp_pc[i])) begin
          miscompares++;
          $display("FAIL wrap_pc[%0d] got=%h/%h exp=%h/%h", i, w_seen[i].pc,
                   w_seen[i].instr, exp_pc[i], mem_word(exp_pc[i]));
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic       ok;
    logic [7:0] target;
    do_reset();
    lat = 2;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (buffered.size() == 3 && inflight.size() == 1 && inflight[0].due <= cyc)
        ok = 1'b1;
      else
        tick(1'b0, 1'b0, 8'h00);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL simul_setup got=timeout exp=3 buffered+arrival");
    end
    target = 8'($urandom);
    tick(1'b1, 1'b1, target);
    vectors++;
    if (last_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_mask got valid=%b exp=0", last_valid);
    end
    tick(1'b1, 1'b0, 8'h00);
    vectors++;
    if (last_valid !== 1'b0 || last_req !== 1'b1 || last_addr !== (target & 8'hFC)) begin
      miscompares++;
      $display("FAIL simul_after got valid=%b req=%b@%h exp 0/1@%h",
               last_valid, last_req, last_addr, target & 8'hFC);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat = int'($urandom_range(1, 3));
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 0) lat = int'($urandom_range(1, 3));
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 8'($urandom));
    end
  endtask

  task automatic test_midop_reset();
    logic ok;
    do_reset();
    lat = 3;
    wait_two_inflight(ok);
    tick(1'b1, 1'b1, 8'h84);
    tick(1'b1, 1'b0, 8'h00);
    vectors++;
    if (!ok || inflight.size() == 0 || !inflight[0].stale) begin
      miscompares++;
      $display("FAIL midrst_setup got=not draining exp=draining");
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_async got req=%b valid=%b addr=%h exp 0/0/00",
               imem_req, if_valid, imem_addr);
    end
    lat = 1;
    do_reset();
    check_start("midrst");
    repeat (6) tick(1'b1, 1'b0, 8'h00);
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    logic ok;
    do_reset();
    lat = 1;
    repeat (6) tick(1'b1, 1'b0, 8'h00);
    repeat (5) tick(1'b0, 1'b0, 8'h00);
    lat = 3;
    wait_two_inflight(ok);
    tick(1'b1, 1'b1, 8'h20);
    repeat (6) tick(1'b1, 1'b0, 8'h00);
    vectors++;
    if (!ok || perf_fetched !== 32'(n_fetched) || perf_stall !== 32'(n_stall)
        || perf_flushed !== 32'(n_flushed) || perf_stall !== 32'd5) begin
      miscompares++;
      $display("FAIL perf got=%0d/%0d/%0d exp=%0d/%0d(5)/%0d", perf_fetched,
               perf_stall, perf_flushed, n_fetched, n_stall, n_flushed);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    salt        = $urandom;
    lat         = 1;
    w_pend      = 1'b0;
    w_pend_addr = 8'h00;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_wrap();
    test_simultaneous();
    test_random();
    test_midop_reset();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
